// File: rtl/conv3x3_pkg.sv
// rtl/conv3x3_pkg.sv - mode encodings, preset kernels and tap states for conv3x3_stream
package conv3x3_pkg;

    localparam int NUM_TAPS = 9;

    localparam logic [1:0] MODE_PROG  = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_LAPL  = 2'd3;

    localparam int KERN_GAUSS [NUM_TAPS] = '{ 1,  2,  1,  2, 4,  2,  1,  2,  1};
    localparam int KERN_SHARP [NUM_TAPS] = '{ 0, -1,  0, -1, 5, -1,  0, -1,  0};
    localparam int KERN_LAPL  [NUM_TAPS] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

    localparam logic [3:0] SHIFT_GAUSS = 4'd4;
    localparam logic [3:0] SHIFT_SHARP = 4'd0;
    localparam logic [3:0] SHIFT_LAPL  = 4'd0;

    // Tap FSM: the state is the index of the next sample to accept.
    typedef enum logic [3:0] {
        TAP0 = 4'd0, TAP1 = 4'd1, TAP2 = 4'd2, TAP3 = 4'd3, TAP4 = 4'd4,
        TAP5 = 4'd5, TAP6 = 4'd6, TAP7 = 4'd7, TAP8 = 4'd8
    } tap_e;

    // Preset coefficient lookup; programmable mode and out-of-range taps give 0.
    function automatic int preset_coef(input logic [1:0] m, input logic [3:0] idx);
        int k;
        k = 0;
        if (idx < 4'd9) begin
            case (m)
                MODE_GAUSS: k = KERN_GAUSS[idx];
                MODE_SHARP: k = KERN_SHARP[idx];
                MODE_LAPL:  k = KERN_LAPL[idx];
                default:    k = 0;
            endcase
        end
        return k;
    endfunction

    function automatic logic [3:0] preset_shift(input logic [1:0] m);
        case (m)
            MODE_GAUSS: return SHIFT_GAUSS;
            MODE_SHARP: return SHIFT_SHARP;
            MODE_LAPL:  return SHIFT_LAPL;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv3x3_requant.sv
// rtl/conv3x3_requant.sv - combinational round, arithmetic shift and clamp to pixel range
module conv3x3_requant
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21,
    parameter int ROUND  = 1
) (
    input  logic signed [ACC_W-1:0]  sum,    // full window sum
    input  logic        [3:0]        shift,  // right-shift amount
    output logic        [DATA_W-1:0] pix     // clamped pixel
);

    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << DATA_W) - 1);

    // One guard bit so the rounding add can never wrap.
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        rounded = {sum[ACC_W-1], sum};
        if (ROUND != 0 && shift != 4'd0) begin
            rounded = rounded + ((ACC_W+1)'(1) << (shift - 4'd1));
        end
        shifted = rounded >>> shift;
        if (shifted[ACC_W]) begin
            pix = '0;
        end else if (shifted > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution with preset and programmable kernels
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ROUND  = 1,
    parameter int ACC_W  = DATA_W + COEF_W + 5
) (
    input  logic                     clk,         // single clock
    input  logic                     rst,         // synchronous, active-high
    input  logic                     sin_en,      // sample strobe
    input  logic        [DATA_W-1:0] in_data,     // pixel, taps 0..8 row-major
    input  logic        [1:0]        mode,        // 0 prog, 1 gauss, 2 sharpen, 3 laplacian
    input  logic        [3:0]        shift,       // right shift, programmable mode only
    input  logic                     win_clr,     // abort current window
    input  logic                     coef_we,     // shadow coefficient write strobe
    input  logic        [3:0]        coef_idx,    // coefficient index 0..8
    input  logic signed [COEF_W-1:0] coef_data,   // coefficient value
    output logic        [DATA_W-1:0] cbit_out,    // filtered pixel
    output logic                     sys_enable,  // one-cycle valid pulse
    output logic        [3:0]        tap_idx      // next tap to accept
);

    tap_e tap_q, tap_d;

    logic        [1:0]  mode_q;
    logic        [3:0]  shift_q;
    logic signed [ACC_W-1:0] acc;

    logic signed [COEF_W-1:0] shadow [NUM_TAPS];
    logic signed [COEF_W-1:0] active [NUM_TAPS];

    logic accept;
    logic signed [COEF_W-1:0]      coef_cur;
    logic signed [DATA_W:0]        pix_s;
    logic signed [COEF_W+DATA_W:0] prod;
    logic signed [ACC_W-1:0]       prod_ext;
    logic signed [ACC_W-1:0]       win_sum;
    logic        [DATA_W-1:0]      requant_pix;

    assign accept  = sin_en & ~win_clr;
    assign tap_idx = tap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q <= TAP0;
        end else begin
            tap_q <= tap_d;
        end
    end

    always_comb begin
        tap_d = tap_q;
        if (win_clr) begin
            tap_d = TAP0;
        end else if (sin_en) begin
            tap_d = (tap_q == TAP8) ? TAP0 : tap_e'(tap_q + 4'd1);
        end
    end

    // Tap 0 sees the live mode and the shadow set, because the latches and the
    // active set only take those values on this same edge.
    always_comb begin
        coef_cur = '0;
        if (tap_q == TAP0) begin
            if (mode == MODE_PROG) coef_cur = shadow[0];
            else                   coef_cur = COEF_W'(preset_coef(mode, 4'd0));
        end else begin
            if (mode_q == MODE_PROG) coef_cur = active[tap_q];
            else                     coef_cur = COEF_W'(preset_coef(mode_q, tap_q));
        end
    end

    assign pix_s    = signed'({1'b0, in_data});
    assign prod     = coef_cur * pix_s;
    assign prod_ext = {{(ACC_W-COEF_W-DATA_W-1){prod[COEF_W+DATA_W]}}, prod};
    assign win_sum  = acc + prod_ext;

    conv3x3_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ROUND  (ROUND)
    ) u_requant (
        .sum   (win_sum),
        .shift (shift_q),
        .pix   (requant_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cbit_out   <= '0;
            sys_enable <= 1'b0;
            mode_q     <= MODE_GAUSS;
            shift_q    <= SHIFT_GAUSS;
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= COEF_W'(KERN_GAUSS[i]);
                active[i] <= COEF_W'(KERN_GAUSS[i]);
            end
        end else begin
            sys_enable <= 1'b0;

            if (coef_we && coef_idx < 4'd9) begin
                shadow[coef_idx] <= coef_data;
            end

            if (win_clr) begin
                acc <= '0;
            end else if (accept) begin
                if (tap_q == TAP0) begin
                    acc     <= prod_ext;
                    mode_q  <= mode;
                    shift_q <= (mode == MODE_PROG) ? shift : preset_shift(mode);
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        active[i] <= shadow[i];
                    end
                end else if (tap_q == TAP8) begin
                    cbit_out   <= requant_pix;
                    sys_enable <= 1'b1;
                end else begin
                    acc <= win_sum;
                end
            end
        end
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised 3x3 convolution engine for the image-filter path. It accepts a raster-ordered 9-sample window one pixel per enabled clock and multiply-accumulates it against a selectable kernel: Gaussian, sharpen, Laplacian, or a programmable signed bank. The result is rounded, shifted and clamped to pixel range. It sits between the UART pixel receiver and the UART transmit/result stage, and generalises the fixed Gaussian averager with widths, kernels, rounding, saturation and window abort.

## Interface
Parameters:
- DATA_W, 8, pixel width (unsigned).
- COEF_W, 8, coefficient width (signed two's complement).
- ROUND, 1, when 1 add 2^(shift-1) before shifting (only if shift>0).
- ACC_W, DATA_W+COEF_W+5, accumulator width (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sin_en  in  1  sample strobe; in_data is accepted on every posedge where sin_en=1.
- in_data  in  DATA_W  pixel sample, window order taps 0..8 (row-major).
- mode  in  2  0=programmable, 1=Gaussian, 2=sharpen, 3=Laplacian.
- shift  in  4  right-shift amount, used in mode 0 only.
- win_clr  in  1  abort the current window.
- coef_we  in  1  coefficient write strobe.
- coef_idx  in  4  coefficient index 0..8; values 9..15 are ignored.
- coef_data  in  COEF_W  signed coefficient value.
- cbit_out  out  DATA_W  filtered pixel, registered.
- sys_enable  out  1  one-cycle pulse marking cbit_out valid.
- tap_idx  out  4  next tap to be accepted (0..8).

## Operation
- Preset kernels (row-major):
  - Gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4.
  - Sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0.
  - Laplacian: -1 -1 -1 / -1 8 -1 / -1 -1 -1, shift 0.
- Programmable bank:
  - Two register sets: a shadow set written by coef_we, and an active set used for computation.
  - The active set is loaded from the shadow set at tap 0 acceptance.
  - Reset loads both sets with the Gaussian coefficients.
- Start of window: mode and shift are latched at tap 0. Changes to mode, shift or coefficients mid-window do not affect the current window.
- Tap counter: 0..8. Each accepted sample performs acc += coef[tap] * zero-extended(in_data) and tap increments. At tap 8, tap wraps to 0.
- Tap 0 acceptance loads the accumulator (acc = product) rather than adding to it. There is no carry between windows.
- Finish, at tap 8 acceptance:
  - s = acc + product.
  - If ROUND=1 and shift>0, s += 1<<(shift-1).
  - s is arithmetic-shifted right by shift.
  - The result is clamped to [0, 2^DATA_W-1] and registered into cbit_out; sys_enable pulses.
- win_clr: on any clk with win_clr=1, tap is set to 0 and acc to 0, and no output is produced. If sin_en is also 1, win_clr wins and the sample is discarded.
- Gaps (sin_en=0) are allowed anywhere in a window. State holds during gaps.
- Reset values: cbit_out=0, sys_enable=0, tap_idx=0, acc=0, coefficient sets=Gaussian, latched mode=Gaussian. Reset mid-window drops the partial window.

## Timing
- Pixel rate: one sample per clock at full rate. A new window may begin on the cycle right after tap 8.
- Latency: cbit_out and sys_enable update on the edge that accepts tap 8, so they are visible in the following cycle.
- sys_enable is high for exactly one cycle per completed window, then returns to 0.
- cbit_out holds its value until the next completion.
- A coefficient write on the same edge as tap 0 acceptance: the write lands in the shadow set, and the active set copies the pre-write shadow value. The write takes effect in the next window.
- Nothing is accepted while rst=1. Outputs reach their reset values on the first edge with rst=1.

## Structure
- Package conv3x3_pkg contains:
  - the mode encoding localparams,
  - the three preset 9-entry coefficient arrays,
  - the preset shift values.
- Sub-module conv3x3_requant is purely combinational: round, arithmetic shift, clamp from ACC_W to DATA_W. It is instantiated once, at the finish stage.
- The top level holds the tap FSM (states are the tap values 0..8), the MAC, the coefficient banks and the output registers.

## Test plan
- Gaussian mode, nine samples of 100 back-to-back -> cbit_out=100, sys_enable high for exactly 1 cycle; repeat with 9 gapped samples -> same result.
- Sharpen:
  - center 200, neighbours 0 -> 1000 clamped to 255.
  - center 0, neighbours 255 -> -1020 clamped to 0.
- Laplacian:
  - uniform 50 -> 0.
  - center 40, neighbours 30 -> 80.
- Mode 0, write all coefficients 1, shift=3, ROUND=1, nine samples of 8 -> (72+4)>>3=9. A coefficient write during the window only changes the next window's result.
- Gaussian, 4 samples then win_clr (with sin_en=1 on the same cycle), then nine samples of 16 -> exactly one output of 16, tap_idx=0 after the clear.
- rst asserted after tap 5, then released, then nine samples of 100 (Gaussian) -> exactly one output of 100. All outputs are 0 while in reset, and a Gaussian-restored kernel is confirmed in mode 0.
